// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants, opcodes and helpers for the multiply/divide unit
// Contents: FSM state encodings, iteration count, INT_MIN, opcode enum, magnitude helper.
package multdiv_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] INT_MIN    = 32'h80000000;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } opcode_t;

    // Two's-complement magnitude; INT_MIN maps to 0x80000000 read as unsigned.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// rtl/multdiv_if.sv - issue / result / write-back bundle of the multiply/divide unit
// Ports: ctrl_MULT, ctrl_DIV, data_operandA/B, ctrl_destReg (issuer -> unit);
//        ctrl_busy, data_resultRDY, data_result, data_exception,
//        wb_writeEnable, wb_writeReg, wb_writeData (unit -> issuer / register file).
interface multdiv_if;

    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_destReg;
    logic        ctrl_busy;
    logic        data_resultRDY;
    logic [31:0] data_result;
    logic        data_exception;
    logic        wb_writeEnable;
    logic [4:0]  wb_writeReg;
    logic [31:0] wb_writeData;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_destReg,
        input  ctrl_busy, data_resultRDY, data_result, data_exception,
               wb_writeEnable, wb_writeReg, wb_writeData
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_destReg,
        output ctrl_busy, data_resultRDY, data_result, data_exception,
               wb_writeEnable, wb_writeReg, wb_writeData
    );

endinterface

// File: rtl/addsub33.sv
// rtl/addsub33.sv - 33-bit adder/subtractor shared by the Booth and divide datapaths
// Ports: a, b (33-bit operands), sub (1 = a - b, 0 = a + b), sum (33-bit result).
module addsub33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum
);

    assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/multdiv_wb.sv
// rtl/multdiv_wb.sv - 32-cycle signed multiply (radix-2 Booth) / divide (restoring) with write-back
// Ports: clock, ctrl_reset_n (sync active-low), bus (multdiv_if.slave).
module multdiv_wb
    import multdiv_pkg::*;
(
    input  logic      clock,
    input  logic      ctrl_reset_n,
    multdiv_if.slave  bus
);

    localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

    logic [1:0]  state;
    logic [4:0]  count;
    opcode_t     opReg;
    logic [4:0]  destReg;
    logic [31:0] operandReg;   // multiplicand, or divisor magnitude
    logic [63:0] product;      // Booth {acc, multiplier}; divide keeps the quotient in [31:0]
    logic        boothBit;     // Booth q(-1)
    logic [31:0] remainder;
    logic        negQuot;
    logic        divZero;
    logic        divOvf;
    logic [31:0] resultHold;

    logic        issueValid;
    logic [32:0] asA;
    logic [32:0] asB;
    logic        asSub;
    logic [32:0] asSum;
    logic [31:0] doneResult;
    logic        doneExc;
    logic        isDone;

    assign issueValid = (state == IDLE) && (bus.ctrl_MULT ^ bus.ctrl_DIV);

    // Operand steering for the shared adder.  The Booth accumulator is
    // sign-extended to 33 bits so that subtracting INT_MIN cannot overflow.
    always_comb begin
        asA   = '0;
        asB   = '0;
        asSub = 1'b0;
        if (opReg == OP_MULT) begin
            asA   = {product[63], product[63:32]};
            asSub = product[0] & ~boothBit;
            asB   = (product[0] ^ boothBit) ? {operandReg[31], operandReg} : 33'd0;
        end else begin
            // Trial subtract of the divisor from the remainder shifted left by one.
            asA   = {remainder, product[31]};
            asB   = {1'b0, operandReg};
            asSub = 1'b1;
        end
    end

    addsub33 u_addsub (
        .a   (asA),
        .b   (asB),
        .sub (asSub),
        .sum (asSum)
    );

    always_comb begin
        doneResult = product[31:0];
        doneExc    = 1'b0;
        if (opReg == OP_MULT) begin
            doneExc = ~((&product[63:31]) | ~(|product[63:31]));
        end else if (divZero) begin
            doneResult = '0;
            doneExc    = 1'b1;
        end else begin
            doneResult = negQuot ? -product[31:0] : product[31:0];
            doneExc    = divOvf;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            state      <= IDLE;
            count      <= '0;
            opReg      <= OP_MULT;
            destReg    <= '0;
            operandReg <= '0;
            product    <= '0;
            boothBit   <= 1'b0;
            remainder  <= '0;
            negQuot    <= 1'b0;
            divZero    <= 1'b0;
            divOvf     <= 1'b0;
            resultHold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issueValid) begin
                        state     <= RUN;
                        count     <= '0;
                        destReg   <= bus.ctrl_destReg;
                        boothBit  <= 1'b0;
                        remainder <= '0;
                        negQuot   <= bus.data_operandA[31] ^ bus.data_operandB[31];
                        divZero   <= (bus.data_operandB == '0);
                        divOvf    <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
                        if (bus.ctrl_MULT) begin
                            opReg      <= OP_MULT;
                            operandReg <= bus.data_operandA;
                            product    <= {32'd0, bus.data_operandB};
                        end else begin
                            opReg      <= OP_DIV;
                            operandReg <= magnitude(bus.data_operandB);
                            product    <= {32'd0, magnitude(bus.data_operandA)};
                        end
                    end
                end
                RUN: begin
                    if (opReg == OP_MULT) begin
                        // Add/subtract then arithmetic shift right of {acc, multiplier}.
                        product  <= {asSum, product[31:1]};
                        boothBit <= product[0];
                    end else if (!asSum[32]) begin
                        remainder     <= asSum[31:0];
                        product[31:0] <= {product[30:0], 1'b1};
                    end else begin
                        remainder     <= asA[31:0];
                        product[31:0] <= {product[30:0], 1'b0};
                    end
                    count <= count + 5'd1;
                    if (count == LAST_ITER) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    resultHold <= doneResult;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign isDone             = (state == DONE);
    assign bus.ctrl_busy      = (state != IDLE);
    assign bus.data_resultRDY = isDone;
    assign bus.data_exception = isDone & doneExc;
    assign bus.data_result    = isDone ? doneResult : resultHold;
    assign bus.wb_writeData   = isDone ? doneResult : resultHold;
    assign bus.wb_writeReg    = isDone ? destReg : 5'd0;
    assign bus.wb_writeEnable = isDone & (destReg != 5'd0) & ~doneExc;

endmodule

// File: tb/tb_multdiv_wb.sv
// tb/tb_multdiv_wb.sv - self-checking bench for multdiv_wb
module tb_multdiv_wb;

    typedef struct {
        logic        isDiv;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic [31:0] expResult;
        logic        expExc;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic        exc;
        logic        we;
        logic [4:0]  dest;
        int          issueEdge;
    } exp_t;

    logic clock = 1'b0;
    logic ctrl_reset_n;

    int nCompared = 0;
    int nMismatch = 0;
    int cycleCnt  = 0;
    int rdyCount  = 0;
    exp_t sbq[$];
    vec_t vecs[13];

    always #5 clock = ~clock;
    always @(posedge clock) cycleCnt++;

    multdiv_if bus ();

    multdiv_wb dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatch++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic issue(input logic isDiv, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, output int issueEdge);
        @(negedge clock);
        bus.ctrl_MULT     = ~isDiv;
        bus.ctrl_DIV      = isDiv;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_destReg  = dest;
        issueEdge         = cycleCnt + 1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
    endtask

    task automatic pushExp(input logic [31:0] result, input logic exc,
                           input logic [4:0] dest, input int issueEdge);
        exp_t e;
        e.result    = result;
        e.exc       = exc;
        e.we        = (dest != 5'd0) && !exc;
        e.dest      = dest;
        e.issueEdge = issueEdge;
        sbq.push_back(e);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (sbq.size() == 0 && bus.ctrl_busy === 1'b0) return;
        end
        nCompared++;
        nMismatch++;
        $display("FAIL wait_idle: actual=timeout required=idle");
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (bus.data_resultRDY === 1'b1) begin
            rdyCount++;
            if (sbq.size() == 0) begin
                nCompared++;
                nMismatch++;
                $display("FAIL unexpected_rdy: actual=1 required=0");
            end else begin
                e = sbq.pop_front();
                check("result",      bus.data_result,    e.result);
                check("exception",   bus.data_exception, 32'(e.exc));
                check("writeEnable", bus.wb_writeEnable, 32'(e.we));
                check("writeReg",    bus.wb_writeReg,    32'(e.dest));
                check("writeData",   bus.wb_writeData,   e.result);
                check("latency",     32'(cycleCnt - e.issueEdge), 32'd32);
            end
        end else begin
            check("idle_writeEnable", bus.wb_writeEnable, 32'd0);
            check("idle_exception",   bus.data_exception, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int edgeN;
        int rdyBefore;

        vecs[0]  = '{1'b0, 32'd7,          32'hFFFFFFFA, 5'd5,  32'hFFFFFFD6, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        5'd3,  32'hFFFFFFFD, 1'b0};
        vecs[2]  = '{1'b1, 32'd5,          32'd0,        5'd4,  32'h00000000, 1'b1};
        vecs[3]  = '{1'b0, 32'h00010000,   32'h00010000, 5'd6,  32'h00000000, 1'b1};
        vecs[4]  = '{1'b0, 32'h80000000,   32'd1,        5'd7,  32'h80000000, 1'b0};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 5'd8,  32'h80000000, 1'b1};
        vecs[6]  = '{1'b1, 32'd100,        32'hFFFFFFF9, 5'd9,  32'hFFFFFFF2, 1'b0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd10, 32'h00000001, 1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 5'd11, 32'h0000000E, 1'b0};
        vecs[9]  = '{1'b0, 32'h7FFFFFFF,   32'd2,        5'd12, 32'hFFFFFFFE, 1'b1};
        vecs[10] = '{1'b1, 32'd7,          32'd7,        5'd13, 32'h00000001, 1'b0};
        vecs[11] = '{1'b0, 32'h80000000,   32'h80000000, 5'd14, 32'h00000000, 1'b1};
        vecs[12] = '{1'b1, 32'd0,          32'd5,        5'd15, 32'h00000000, 1'b0};

        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_destReg  = '0;
        ctrl_reset_n      = 1'b0;
        repeat (3) @(negedge clock);

        check("reset_busy",   bus.ctrl_busy,      32'd0);
        check("reset_rdy",    bus.data_resultRDY, 32'd0);
        check("reset_result", bus.data_result,    32'd0);
        check("reset_wreg",   bus.wb_writeReg,    32'd0);
        check("reset_wdata",  bus.wb_writeData,   32'd0);
        ctrl_reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].isDiv, vecs[i].a, vecs[i].b, vecs[i].dest, edgeN);
            pushExp(vecs[i].expResult, vecs[i].expExc, vecs[i].dest, edgeN);
            check("busy_running", bus.ctrl_busy, 32'd1);
            waitIdle();
            check("result_hold", bus.data_result, vecs[i].expResult);
        end

        // DIV pulse in the middle of a MULT is dropped.
        rdyBefore = rdyCount;
        issue(1'b0, 32'd3, 32'd4, 5'd20, edgeN);
        pushExp(32'd12, 1'b0, 5'd20, edgeN);
        repeat (9) @(negedge clock);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd10;
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
        waitIdle();
        repeat (40) @(negedge clock);
        check("one_rdy_during_run", 32'(rdyCount - rdyBefore), 32'd1);

        // MULT and DIV together are ignored.
        rdyBefore = rdyCount;
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.ctrl_DIV  = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        check("both_high_busy", bus.ctrl_busy, 32'd0);
        repeat (40) @(negedge clock);
        check("both_high_no_rdy", 32'(rdyCount - rdyBefore), 32'd0);

        // Reset about 20 cycles into RUN, with an issue pulse during reset.
        rdyBefore = rdyCount;
        issue(1'b0, 32'd9, 32'd9, 5'd1, edgeN);
        repeat (19) @(negedge clock);
        check("pre_reset_busy", bus.ctrl_busy, 32'd1);
        ctrl_reset_n  = 1'b0;
        bus.ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_reset_n  = 1'b1;
        bus.ctrl_MULT = 1'b0;
        check("abort_busy",   bus.ctrl_busy,      32'd0);
        check("abort_rdy",    bus.data_resultRDY, 32'd0);
        check("abort_result", bus.data_result,    32'd0);
        check("abort_wdata",  bus.wb_writeData,   32'd0);
        check("abort_wreg",   bus.wb_writeReg,    32'd0);
        repeat (40) @(negedge clock);
        check("abort_no_rdy", 32'(rdyCount - rdyBefore), 32'd0);

        // Destination r0: result delivered, no register write.
        issue(1'b0, 32'd5, 32'd6, 5'd0, edgeN);
        pushExp(32'd30, 1'b0, 5'd0, edgeN);
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/multdiv_wb.md
MULTDIV_WB -- requirements
Module: multdiv_wb

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clock  in  1  rising-edge clock shared with the register file.
REQ-003 ctrl_reset_n  in  1  synchronous active-low reset, sampled on the rising clock edge.
REQ-004 ctrl_MULT  in  1  single-cycle pulse; issues a signed multiply.
REQ-005 ctrl_DIV  in  1  single-cycle pulse; issues a signed divide.
REQ-006 data_operandA  in  32  dividend or multiplicand, taken from register-file read port A.
REQ-007 data_operandB  in  32  divisor or multiplier, taken from register-file read port B.
REQ-008 ctrl_destReg  in  5  destination register index for the result.
REQ-009 ctrl_busy  out  1  high while an operation is in flight.
REQ-010 data_resultRDY  out  1  one-cycle pulse; result is valid in this cycle.
REQ-011 data_result  out  32  quotient, or the low 32 bits of the product.
REQ-012 data_exception  out  1  flags overflow or divide-by-zero; valid only with data_resultRDY.
REQ-013 wb_writeEnable / wb_writeReg / wb_writeData  out  1/5/32  drive the register-file write port.

Function
REQ-014 The state machine SHALL have three states.
- Transitions: IDLE->RUN on a valid issue; RUN->DONE after iteration 32; DONE->IDLE after one cycle.
REQ-015 A valid issue SHALL be exactly one of ctrl_MULT or ctrl_DIV high in IDLE, sampled on a clock edge (E0).
- On a valid issue the block latches the operands, ctrl_destReg and the opcode, and sets the 5-bit counter to 0.
REQ-016 If ctrl_MULT and ctrl_DIV are both high in the same cycle, the block SHALL ignore both and stay in IDLE.
REQ-017 Any issue pulse seen while in RUN or DONE SHALL be ignored; the operation in flight is unaffected.
REQ-018 RUN SHALL do one iteration per cycle for exactly 32 cycles; the counter runs 0..31 and wraps to 0 on entering DONE.
REQ-019 data_resultRDY SHALL be high only in DONE, so it is seen in the cycle after edge E0+32.
- Latency is fixed at 32 cycles for every operand value, including the exception cases.
REQ-020 ctrl_busy SHALL be high in RUN and DONE, and low in IDLE.
REQ-021 Multiply SHALL use radix-2 Booth with a 64-bit product register.
- data_result is product[31:0].
- data_exception is 1 when product[63:31] is not all-zero and not all-one.
REQ-022 Divide SHALL use restoring division on the operand magnitudes, with a 33-bit add/subtract.
- The quotient truncates toward zero and is negated when the operand signs differ.
- The remainder is discarded.
REQ-023 Divide by zero SHALL give data_result=0 and data_exception=1.
REQ-024 0x80000000 / 0xFFFFFFFF SHALL give data_result=0x80000000 and data_exception=1.
REQ-025 In DONE the write-back outputs SHALL be as follows.
- wb_writeEnable=1, except that it is 0 when the latched destination register is 0 or data_exception=1.
- wb_writeReg is the latched ctrl_destReg.
- wb_writeData equals data_result.
REQ-026 Outside DONE: wb_writeEnable, data_resultRDY and data_exception SHALL be 0, and data_result and wb_writeData SHALL hold their last value.

Reset
REQ-027 With ctrl_reset_n=0 at an edge, the next state SHALL be IDLE.
- Counter, product and remainder registers are cleared.
- All outputs are 0.
REQ-028 A reset during RUN or DONE SHALL abort the operation: no data_resultRDY and no write-back are produced for it.
REQ-029 An issue pulse in the same cycle as reset SHALL be ignored.

Structure
REQ-030 The shared package multdiv_pkg SHALL define the following.
- State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- ITER_COUNT=32.
- INT_MIN=32'h80000000.
- Opcode encodings OP_MULT and OP_DIV.
REQ-031 The 33-bit add/subtract SHALL be a single sub-module, addsub33, shared by the Booth and divide datapaths.

Verification
REQ-032 MULT with A=7, B=-6, dest=5 -> data_resultRDY after exactly 32 cycles, result 0xFFFFFFD6, exception=0, write to r5.
REQ-033 DIV with A=-7, B=2, dest=3 -> result 0xFFFFFFFD; DIV with A=5, B=0 -> result 0, exception=1, wb_writeEnable=0.
REQ-034 MULT with A=0x00010000, B=0x00010000 -> result 0, exception=1; MULT with A=0x80000000, B=1 -> result 0x80000000, exception=0.
REQ-035 DIV pulse 10 cycles into a MULT -> ignored; exactly one data_resultRDY, carrying the multiply result.
- A cycle with ctrl_MULT and ctrl_DIV both high -> ctrl_busy stays 0.
REQ-036 Reset asserted at RUN cycle 20 -> outputs 0 next cycle and no data_resultRDY.
- A MULT issued after reset with dest=0 -> data_resultRDY=1 but wb_writeEnable=0.
